// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller and its upstream feeders.
// Lane indices name the detector bits of sensor_raw / lane_det.
package traffic_pkg;

    localparam int COUNT_W   = 5;
    localparam int COUNT_MAX = 31;

    localparam int LANE_M1 = 0;
    localparam int LANE_M2 = 1;
    localparam int LANE_MT = 2;
    localparam int LANE_S  = 3;

    typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/sensor_debounce.sv
// One detector lane: two-flop synchroniser, stability debounce and rising-edge detect.
// Runs every cycle regardless of the counting enable.
module sensor_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            // The cycle that would make the count reach DEB_CYCLES accepts the level instead.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/vehicle_count_sampler.sv
// Counts debounced vehicle arrivals over a fixed window of enabled cycles and
// publishes the saturated total once per window.
module vehicle_count_sampler
    import traffic_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int WINDOW_CYCLES = 1024,
    parameter int DEB_CYCLES    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] sensor_raw,
    output logic [COUNT_W-1:0]   NO_of_vehical,
    output logic                 count_valid,
    output logic                 overflow,
    output logic [NUM_LANES-1:0] lane_det
);

    localparam int WCNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int INC_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES + 1) : 1;
    localparam int SUM_W  = COUNT_W + 4;

    logic [NUM_LANES-1:0] rise;
    logic [INC_W-1:0]     inc;
    logic [SUM_W-1:0]     sum;
    logic                 sum_sat;
    count_t               sum_clamped;
    logic                 terminal;

    logic [WCNT_W-1:0]    wcnt;
    count_t               acc;
    logic                 sat;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (sensor_raw[g]),
            .level (lane_det[g]),
            .rise  (rise[g])
        );
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            inc = inc + INC_W'(rise[i]);
        end
    end

    // Summed wider than the accumulator so the clamp sees the true total.
    assign sum         = SUM_W'(acc) + SUM_W'(inc);
    assign sum_sat     = (sum > SUM_W'(COUNT_MAX));
    assign sum_clamped = sum_sat ? count_t'(COUNT_MAX) : sum[COUNT_W-1:0];
    assign terminal    = en && (wcnt == WCNT_W'(WINDOW_CYCLES - 1));

    // count_valid is a one-cycle qualifier with no back-pressure: NO_of_vehical and
    // overflow change only in that cycle and hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt          <= '0;
            acc           <= '0;
            sat           <= 1'b0;
            NO_of_vehical <= '0;
            overflow      <= 1'b0;
            count_valid   <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (terminal) begin
                wcnt          <= '0;
                acc           <= '0;
                sat           <= 1'b0;
                NO_of_vehical <= sum_clamped;
                overflow      <= sat | sum_sat;
                count_valid   <= 1'b1;
            end else if (en) begin
                wcnt <= wcnt + 1'b1;
                acc  <= sum_clamped;
                sat  <= sat | sum_sat;
            end
        end
    end

endmodule
